// File: rtl/fpmul_unpack_stage_pkg.sv
// Shared widths, constants and the unpacked-operand record for the FP multiply
// unpack stage.
package fpmul_unpack_stage_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = 24;
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_ALL1 = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;

  // One operand after split/classify/flush.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
    logic             is_dn;
  } fp_unpacked_t;

endpackage

// File: rtl/fpmul_unpack_stage_if.sv
// Operand/result bus of the unpack stage, including both valid/ready handshakes.
interface fpmul_unpack_stage_if;
  import fpmul_unpack_stage_pkg::*;

  logic [31:0]      FP_A;
  logic [31:0]      FP_B;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             SIGN_A;
  logic             SIGN_B;
  logic [EXP_W-1:0] EXP_A;
  logic [EXP_W-1:0] EXP_B;
  logic [SIG_W-1:0] SIG_A;
  logic [SIG_W-1:0] SIG_B;
  logic             SIGN_out;
  logic             isNaN;
  logic             isINF_tab;
  logic             isZ_tab;
  logic             isDN;

  modport master (
    output FP_A, FP_B, in_valid, out_ready,
    input  in_ready, out_valid, SIGN_A, SIGN_B, EXP_A, EXP_B, SIG_A, SIG_B,
           SIGN_out, isNaN, isINF_tab, isZ_tab, isDN
  );

  modport slave (
    input  FP_A, FP_B, in_valid, out_ready,
    output in_ready, out_valid, SIGN_A, SIGN_B, EXP_A, EXP_B, SIG_A, SIG_B,
           SIGN_out, isNaN, isINF_tab, isZ_tab, isDN
  );

endinterface

// File: rtl/fpmul_unpack_stage_unpack_fp.sv
// Combinational split of one IEEE-754 single into sign/exponent/significand
// plus class flags. Denormals are flushed to a zero significand.
module unpack_fp
  import fpmul_unpack_stage_pkg::*;
(
  input  logic [31:0]  fp,
  output fp_unpacked_t fields
);

  logic [EXP_W-1:0]  exp_bits;
  logic [FRAC_W-1:0] frac_bits;
  logic              frac_nz;

  assign exp_bits  = fp[30:23];
  assign frac_bits = fp[22:0];
  assign frac_nz   = |frac_bits;

  // Classify the operand and form its significand.
  always_comb begin
    fields      = '0;
    fields.sign = fp[31];
    fields.exp  = exp_bits;
    if (exp_bits == EXP_ALL1) begin
      // INF/NaN keep the raw fraction but never the hidden bit.
      fields.is_nan = frac_nz;
      fields.is_inf = ~frac_nz;
      fields.sig    = {1'b0, frac_bits};
    end else if (exp_bits == EXP_ZERO) begin
      // Zero and denormal both become a zero significand.
      fields.is_zero = 1'b1;
      fields.is_dn   = frac_nz;
      fields.sig     = {SIG_W{1'b0}};
    end else begin
      fields.sig = {1'b1, frac_bits};
    end
  end

endmodule

// File: rtl/fpmul_unpack_stage.sv
// Two-stage unpack front end of the FP multiplier: stage 1 captures the raw
// operands, stage 2 captures the unpacked fields and combined product class.
module fpmul_unpack_stage
  import fpmul_unpack_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fpmul_unpack_stage_if.slave  bus
);

  logic             adv;
  logic             s1_valid_r;
  logic [31:0]      s1_a_r;
  logic [31:0]      s1_b_r;
  fp_unpacked_t     ua;
  fp_unpacked_t     ub;
  logic             nan_c;
  logic             inf_c;
  logic             zero_c;
  logic             dn_c;
  logic             sign_c;

  logic             out_valid_r;
  logic             sign_a_r;
  logic             sign_b_r;
  logic [EXP_W-1:0] exp_a_r;
  logic [EXP_W-1:0] exp_b_r;
  logic [SIG_W-1:0] sig_a_r;
  logic [SIG_W-1:0] sig_b_r;
  logic             sign_out_r;
  logic             nan_r;
  logic             inf_r;
  logic             zero_r;
  logic             dn_r;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv          = bus.out_ready | ~out_valid_r;
  assign bus.in_ready = adv;

  unpack_fp u_unpack_a (.fp(s1_a_r), .fields(ua));
  unpack_fp u_unpack_b (.fp(s1_b_r), .fields(ub));

  // Combine per-operand classes into exclusive product-class flags.
  always_comb begin
    nan_c  = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_zero) | (ua.is_zero & ub.is_inf);
    inf_c  = (ua.is_inf | ub.is_inf) & ~nan_c;
    zero_c = (ua.is_zero | ub.is_zero) & ~nan_c;
    dn_c   = ua.is_dn | ub.is_dn;
    sign_c = ua.sign ^ ub.sign;
  end

  // Stage 1: capture raw operands; data only changes on an actual accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 32'h0000_0000;
      s1_b_r     <= 32'h0000_0000;
    end else if (adv) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_r <= bus.FP_A;
        s1_b_r <= bus.FP_B;
      end
    end
  end

  // Stage 2: capture unpacked fields; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      exp_a_r     <= 8'h00;
      exp_b_r     <= 8'h00;
      sig_a_r     <= 24'h00_0000;
      sig_b_r     <= 24'h00_0000;
      sign_out_r  <= 1'b0;
      nan_r       <= 1'b0;
      inf_r       <= 1'b0;
      zero_r      <= 1'b0;
      dn_r        <= 1'b0;
    end else if (adv) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        sign_a_r   <= ua.sign;
        sign_b_r   <= ub.sign;
        exp_a_r    <= ua.exp;
        exp_b_r    <= ub.exp;
        sig_a_r    <= ua.sig;
        sig_b_r    <= ub.sig;
        sign_out_r <= sign_c;
        nan_r      <= nan_c;
        inf_r      <= inf_c;
        zero_r     <= zero_c;
        dn_r       <= dn_c;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.SIGN_A    = sign_a_r;
  assign bus.SIGN_B    = sign_b_r;
  assign bus.EXP_A     = exp_a_r;
  assign bus.EXP_B     = exp_b_r;
  assign bus.SIG_A     = sig_a_r;
  assign bus.SIG_B     = sig_b_r;
  assign bus.SIGN_out  = sign_out_r;
  assign bus.isNaN     = nan_r;
  assign bus.isINF_tab = inf_r;
  assign bus.isZ_tab   = zero_r;
  assign bus.isDN      = dn_r;

endmodule

// File: tb/tb_fpmul_unpack_stage.sv
// Bench for fpmul_unpack_stage: table of hand-computed vectors plus directed
// stall, streaming and mid-flight reset sequences.
module tb_fpmul_unpack_stage;
  import fpmul_unpack_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fpmul_unpack_stage_if bus ();

  fpmul_unpack_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ga;
    logic [23:0] gb;
    logic        so;
    logic        nan;
    logic        inf;
    logic        z;
    logic        dn;
  } vec_t;

  vec_t vecs [10];
  int   checks = 0;
  int   fails  = 0;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic sa, logic sb,
                              logic [7:0] ea, logic [7:0] eb, logic [23:0] ga,
                              logic [23:0] gb, logic so, logic nan, logic inf,
                              logic z, logic dn);
    vec_t v;
    v.a = a; v.b = b; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
    v.ga = ga; v.gb = gb; v.so = so; v.nan = nan; v.inf = inf; v.z = z; v.dn = dn;
    return v;
  endfunction

  function automatic logic [70:0] exp_bundle(vec_t v);
    return {v.sa, v.sb, v.ea, v.eb, v.ga, v.gb, v.so, v.nan, v.inf, v.z, v.dn};
  endfunction

  function automatic logic [70:0] dut_bundle();
    return {bus.SIGN_A, bus.SIGN_B, bus.EXP_A, bus.EXP_B, bus.SIG_A, bus.SIG_B,
            bus.SIGN_out, bus.isNaN, bus.isINF_tab, bus.isZ_tab, bus.isDN};
  endfunction

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Single operand pair with out_ready high: checks latency and all fields.
  task automatic send_one(input vec_t v, input string name);
    @(negedge clk);
    bus.FP_A = v.a; bus.FP_B = v.b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check_int({name, " in_ready"}, int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_int({name, " out_valid@1"}, int'(bus.out_valid), 0);
    @(negedge clk);
    check_int({name, " out_valid@2"}, int'(bus.out_valid), 1);
    check({name, " fields"}, dut_bundle(), exp_bundle(v));
    check_int({name, " onehot"},
              int'($countones({bus.isNaN, bus.isINF_tab, bus.isZ_tab}) <= 1), 1);
  endtask

  // Four back-to-back operands, optional consumer stall after first result.
  task automatic run_stream(input int stall_len, input string name);
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    int bubbles = 0;
    int in_low = 0;
    int extra = 0;
    logic seen = 1'b0;
    logic prev_stall = 1'b0;
    logic [70:0] snap = '0;
    int order [4] = '{5, 0, 2, 3};
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      bus.in_valid = (sent < 4);
      bus.FP_A = vecs[order[(sent < 4) ? sent : 3]].a;
      bus.FP_B = vecs[order[(sent < 4) ? sent : 3]].b;
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        stall_left = stall_len;
      end
      bus.out_ready = (stall_left == 0);
      #1;
      if (seen && !bus.out_valid) bubbles++;
      if (bus.in_valid && !bus.in_ready) in_low++;
      if (bus.out_valid && !bus.out_ready) begin
        if (prev_stall) check({name, " stall stable"}, dut_bundle(), snap);
        snap = dut_bundle();
        prev_stall = 1'b1;
        stall_left--;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("%s result %0d", name, got), dut_bundle(), exp_bundle(vecs[order[got]]));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    check_int({name, " results delivered"}, got, 4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    check_int({name, " no duplicate"}, extra, 0);
    check_int({name, " bubbles"}, bubbles, 0);
    check_int({name, " in_ready dropped"}, int'(in_low > 0), int'(stall_len > 0));
  endtask

  initial begin
    vecs[0] = mk(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 8'h7F, 8'h80, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(32'h7F800000, 32'h00000000, 1'b0, 1'b0, 8'hFF, 8'h00, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2] = mk(32'hFF800000, 32'h3F800000, 1'b1, 1'b0, 8'hFF, 8'h7F, 24'h000000, 24'h800000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[3] = mk(32'h00000001, 32'h3F800000, 1'b0, 1'b0, 8'h00, 8'h7F, 24'h000000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[4] = mk(32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 8'h7F, 24'h400000, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(32'hC0490FDB, 32'hBF000000, 1'b1, 1'b1, 8'h80, 8'h7E, 24'hC90FDB, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6] = mk(32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 8'hFF, 8'hFF, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[7] = mk(32'h80000000, 32'h807FFFFF, 1'b1, 1'b1, 8'h00, 8'h00, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[8] = mk(32'h00400000, 32'h7F800000, 1'b0, 1'b0, 8'h00, 8'hFF, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[9] = mk(32'h7F7FFFFF, 32'h00800000, 1'b0, 1'b0, 8'hFE, 8'h01, 24'hFFFFFF, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    bus.FP_A = 32'h0; bus.FP_B = 32'h0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_int("reset out_valid", int'(bus.out_valid), 0);
    check_int("reset in_ready", int'(bus.in_ready), 1);
    check("reset outputs", dut_bundle(), 71'd0);

    for (int i = 0; i < 10; i++) send_one(vecs[i], $sformatf("vec%0d", i));

    run_stream(3, "stall");
    run_stream(0, "stream");

    // Reset one cycle after an operand is accepted: it must vanish.
    @(negedge clk);
    bus.FP_A = vecs[0].a; bus.FP_B = vecs[0].b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_int("midrst out_valid", int'(bus.out_valid), 0);
    check("midrst outputs", dut_bundle(), 71'd0);
    begin
      int spurious = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus.out_valid) spurious++;
      end
      check_int("midrst discarded", spurious, 0);
    end
    send_one(vecs[5], "post-rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fpmul_unpack_stage.md
FPMUL_UNPACK_STAGE -- requirements
Module: fpmul_unpack_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port FP_A, input, 32 bits: IEEE-754 single operand A.
REQ-004 SHALL have port FP_B, input, 32 bits: IEEE-754 single operand B.
REQ-005 SHALL have port in_valid, input, 1 bit: FP_A/FP_B valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output handshake.
REQ-008 SHALL have ports SIGN_A, SIGN_B, output, 1 bit each: operand signs.
REQ-009 SHALL have ports EXP_A, EXP_B, output, 8 bits each: biased exponents.
REQ-010 SHALL have ports SIG_A, SIG_B, output, 24 bits each: significands with hidden bit in [23].
REQ-011 SHALL have ports SIGN_out, isNaN, isINF_tab, isZ_tab, output, 1 bit each: combined product sign and class flags, matching downstream stage inputs.
REQ-012 SHALL have port isDN, output, 1 bit: at least one operand was denormal and flushed.

Function
REQ-013 SHALL be a 2-stage pipeline: stage 1 registers FP_A/FP_B, stage 2 registers unpacked fields and flags; latency 2 cycles from accepted input to out_valid with no stall.
REQ-014 SHALL advance both stages when adv = out_ready OR NOT out_valid; in_ready SHALL equal adv (combinational).
REQ-015 Stage-1 valid SHALL load in_valid AND in_ready on adv; stage-2 valid (out_valid) SHALL load stage-1 valid on adv; all registers SHALL hold when adv=0.
REQ-016 Output data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 Per operand: SIGN=bit31, EXP=bits30:23, frac=bits22:0.
REQ-018 Class: EXP=FF, frac/=0 -> NaN; EXP=FF, frac=0 -> INF; EXP=00 -> zero (frac/=0 also flags denormal); else normal.
REQ-019 SIG SHALL be {1,frac} for normal, {0,frac} for INF/NaN, 24'h000000 for zero/denormal (flush-to-zero).
REQ-020 SIGN_out SHALL be SIGN_A XOR SIGN_B.
REQ-021 isNaN SHALL be NaN_A OR NaN_B OR (INF_A AND Z_B) OR (Z_A AND INF_B).
REQ-022 isINF_tab SHALL be (INF_A OR INF_B) AND NOT isNaN; isZ_tab SHALL be (Z_A OR Z_B) AND NOT isNaN.
REQ-023 At most one of isNaN, isINF_tab, isZ_tab SHALL be 1 in any output.
REQ-024 Simultaneous accept and drain (out_valid=1, out_ready=1, in_valid=1) SHALL sustain 1 result per cycle with no bubble.

Reset
REQ-025 rst=1 SHALL clear both valid bits; out_valid=0 on the cycle after rst is sampled.
REQ-026 rst SHALL clear all data outputs and flags to 0; in_ready SHALL be 1 while out_valid=0.
REQ-027 rst asserted mid-flight SHALL discard in-flight operands; no result emitted for them.

Structure
REQ-028 Shared package SHALL hold EXP_W=8, FRAC_W=23, SIG_W=24, EXP_ALL1=8'hFF, EXP_BIAS=127.
REQ-029 SHALL instantiate sub-module unpack_fp twice (one per operand): combinational split/classify/flush, the inverse of the pack stage.
REQ-030 Flag combine and pipeline registers SHALL reside in fpmul_unpack_stage.

Verification
REQ-031 A=3F800000, B=40000000, out_ready=1 -> 2 cycles later SIG_A=800000, EXP_A=7F, SIG_B=800000, EXP_B=80, all flags 0.
REQ-032 A=7F800000, B=00000000 -> isNaN=1, isINF_tab=0, isZ_tab=0; A=FF800000, B=3F800000 -> isINF_tab=1, SIGN_out=1.
REQ-033 A=00000001, B=3F800000 -> SIG_A=000000, isZ_tab=1, isDN=1.
REQ-034 Back-to-back 4 inputs, out_ready held 0 for 3 cycles after first out_valid -> in_ready drops, outputs stable, all 4 results delivered in order, none lost/duplicated.
REQ-035 rst pulsed 1 cycle after accepting an operand -> out_valid stays 0, outputs 0, next accepted operand emerges 2 cycles later correctly.
